// File: rtl/counter_pkg.sv
// Shared types and helpers for the binary up-counter.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // Mask with the low 'width' bits set; widths of 32 and above give a full word
    function automatic logic [31:0] all_ones(input int unsigned width);
        logic [31:0] mask_v;
        if (width >= 32) begin
            mask_v = 32'hFFFF_FFFF;
        end else begin
            mask_v = (32'd1 << width) - 32'd1;
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for binary_up_counter: clear > load > enabled increment > hold.
// Defining COUNTER_SATURATE_EN makes the increment stop at all-ones instead of wrapping.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_q
);

    localparam logic [31:0]      ONES_WORD = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] MAX_Q     = ONES_WORD[WIDTH-1:0];

    logic [WIDTH-1:0] inc_s;

    // Increment value, wrapping or saturating depending on the build
    always_comb begin
        inc_s = q + WIDTH'(1);
`ifdef COUNTER_SATURATE_EN
        if (q == MAX_Q) begin
            inc_s = MAX_Q;
        end else begin
            inc_s = q + WIDTH'(1);
        end
`else
        if (q == MAX_Q) begin
            inc_s = {WIDTH{1'b0}};
        end else begin
            inc_s = q + WIDTH'(1);
        end
`endif
    end

    // Priority select of the next count
    always_comb begin
        next_q = q;
        if (clr) begin
            next_q = RST_VAL;
        end else if (load) begin
            next_q = load_val;
        end else if (en) begin
            next_q = inc_s;
        end else begin
            next_q = q;
        end
    end

endmodule

// File: rtl/binary_up_counter.sv
// Synchronous binary up-counter with enable, load, clear and terminal count.
// Build option COUNTER_SATURATE_EN: increment saturates at all-ones.
module binary_up_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [31:0]      ONES_WORD = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] MAX_Q     = ONES_WORD[WIDTH-1:0];

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;

    counter_next #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_next (
        .q        (count_r),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .next_q   (next_count_s)
    );

    // Count register; rst is active-low and acts immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= RST_VAL;
        end else begin
            count_r <= next_count_s;
        end
    end

    assign q  = count_r;
    // Terminal count straight off the register, no extra stage
    assign tc = (count_r == MAX_Q);

endmodule

// File: tb/tb_binary_up_counter.sv
// Scoreboard bench for binary_up_counter (8-bit, RST_VAL = 0).
module tb_binary_up_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       tc;

    int unsigned n_total;
    int unsigned n_bad;
    logic [7:0]  model_q;
    logic [7:0]  sb_q[$];

    binary_up_counter #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mdl_next(input logic [7:0] cur, input logic e,
                                            input logic c, input logic l, input logic [7:0] lv);
        logic [7:0] r;
        if (c) r = 8'h00;
        else if (l) r = lv;
        else if (e) begin
`ifdef COUNTER_SATURATE_EN
            r = (cur == 8'hFF) ? 8'hFF : cur + 8'd1;
`else
            r = cur + 8'd1;
`endif
        end else r = cur;
        return r;
    endfunction

    // Called just after a falling edge: drive, predict, check after the rising edge
    task automatic step(input string tag, input logic e, input logic c, input logic l,
                        input logic [7:0] lv);
        logic [7:0] exp_q;
        en = e; clr = c; load = l; load_val = lv;
        model_q = mdl_next(model_q, e, c, l, lv);
        sb_q.push_back(model_q);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_q = sb_q.pop_front();
            check_val({tag, "_q"}, 32'(q), 32'(exp_q));
            check_val({tag, "_tc"}, 32'(tc), 32'(exp_q == 8'hFF));
        end
        @(negedge clk);
    endtask

    initial begin
        n_total = 0; n_bad = 0; model_q = 8'h00;
        rst = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;

        // 1: reset held for two edges with en=1, then release on a falling edge
        #1;
        check_val("rst_q_async", 32'(q), 32'h00);
        check_val("rst_tc", 32'(tc), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_val("rst_q_hold", 32'(q), 32'h00);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step("run10", 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("run10_end", 32'(q), 32'h0A);

        // 2: re-reset, then 300 free-running edges against the model
        rst = 1'b0; model_q = 8'h00;
        #1;
        check_val("rerst_q", 32'(q), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 300; i++) step("free", 1'b1, 1'b0, 1'b0, 8'h00);
`ifdef COUNTER_SATURATE_EN
        check_val("free_end", 32'(q), 32'hFF);
`else
        check_val("free_end", 32'(q), 32'h2C);
`endif

        // 3: load 0xF0 then 15 increments reach terminal count
        step("ld_f0", 1'b1, 1'b0, 1'b1, 8'hF0);
        check_val("ld_f0_q", 32'(q), 32'hF0);
        for (int i = 0; i < 15; i++) step("to_ff", 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("to_ff_q", 32'(q), 32'hFF);
        check_val("to_ff_tc", 32'(tc), 32'h1);

        // 4: clear beats load; load beats increment
        step("clr_ld", 1'b1, 1'b1, 1'b1, 8'h55);
        check_val("clr_wins", 32'(q), 32'h00);
        step("ld_en", 1'b1, 1'b0, 1'b1, 8'h55);
        check_val("ld_no_inc", 32'(q), 32'h55);

        // 5: hold with en=0, then resume
        step("ld_37", 1'b0, 1'b0, 1'b1, 8'h37);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("hold_q", 32'(q), 32'h37);
        step("resume", 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("resume_q", 32'(q), 32'h38);

        // 6: asynchronous reset mid-cycle at 0x80
        step("ld_80", 1'b1, 1'b0, 1'b1, 8'h80);
        #2;
        rst = 1'b0; model_q = 8'h00;
        #1;
        check_val("async_q", 32'(q), 32'h00);
        check_val("async_tc", 32'(tc), 32'h0);
        @(negedge clk);
        check_val("async_hold", 32'(q), 32'h00);
        rst = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("post_rst_q", 32'(q), 32'h01);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/binary_up_counter.md
Name: binary_up_counter

Overview:
- Free-running synchronous binary up-counter. Default width is 8 bits.
- Used as the arithmetic-benchmark reference block for fabric-vs-RTL equivalence runs.
- Adds a count enable, a synchronous load, a synchronous clear and a terminal-count flag.
- With the control inputs tied inactive it reduces to the plain clk/rst/q counter.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- RST_VAL, 0, value loaded into q by reset and by sync clear; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: one clock; asynchronous, active-low reset.
- en  input  1  count enable; tie 1 for free-running operation.
- clr  input  1  synchronous clear to RST_VAL; active-high.
- load  input  1  synchronous parallel load; active-high.
- load_val  input  WIDTH  value captured when load=1.
- q  output  WIDTH  registered count; q[0] is the LSB. The benchmark view exposes q[0]..q[7] as individual bits.
- tc  output  1  terminal count, combinational: 1 when q == all-ones.

Behaviour:
- Async reset: while rst=0, q = RST_VAL immediately, independent of clk.
- Release of reset takes effect at the next rising edge of clk.
- Per rising edge, priority is highest first:
  - clr=1: q <= RST_VAL.
  - else load=1: q <= load_val.
  - else en=1: q <= q+1, modulo 2^WIDTH.
  - else: q holds.
- Wrap-around: from all-ones q becomes 0 on the next enabled edge; no sticky flag.
- Latency: q changes one cycle after the controlling input is sampled. The first increment occurs on the first rising edge with rst=1.
- tc is derived only from q, with no extra register stage. tc=1 during reset only if RST_VAL is all-ones.
- Simultaneous clr and load: clr wins.
- Simultaneous load and en: the load value is taken and is not incremented.
- Reset asserted mid-count: q goes to RST_VAL asynchronously. Counting resumes from RST_VAL after release.
- Outputs are never X after the first reset assertion. No internal state exists beyond q.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: the increment saturates at all-ones. When q is all-ones and en=1, q holds, and tc stays 1 until a clear, load or reset occurs.
- Undefined (default): modulo wrap as specified above.
- Clear, load and reset behave identically in both builds.

Decomposition:
- Package counter_pkg holds:
  - localparam DEFAULT_WIDTH = 8.
  - typedef count_t = logic [DEFAULT_WIDTH-1:0].
  - function all_ones(WIDTH) helper.
- One sub-module: counter_next. It is purely combinational, takes q, en, clr, load, load_val and returns the next q, including the saturate option.
- The top level holds only the async-reset register and the tc compare.

Test Plan:
1. Hold rst=0 for 2 clock cycles with en=1, clr=0, load=0. q=0x00 throughout. Release rst on the falling edge; q=0x01 after the next rising edge and 0x0A after 10 edges.
2. Free-run 300 edges from reset, checked cycle by cycle against a model:
   - q goes 0xFE -> 0xFF with tc=1.
   - q then goes 0xFF -> 0x00 with tc=0; no X on any bit.
   - With COUNTER_SATURATE_EN defined, q stays 0xFF.
3. load=1 with load_val=0xF0 for one edge -> q=0xF0. Then 15 enabled edges -> q=0xFF and tc=1.
4. clr=1 and load=1 in the same cycle with load_val=0x55 -> q=0x00 (clear wins). Then load=1 with en=1 -> q=0x55, not 0x56.
5. en=0 for 5 edges at q=0x37 -> q stays 0x37. Set en=1 -> q=0x38 after the next edge.
6. Assert rst=0 asynchronously mid-cycle while q=0x80 -> q=0x00 before the next clock edge. Release -> counting resumes at 0x01.
